mul_unit: RTL and testbench
===========================

// Module: mul_unit
// PURPOSE
//  Iterative 32x32 integer multiplier that produces the MUL_res operand consumed by
//  the MEM stage result select (ALU vs MUL). Issued from EX with a valid/ready
//  handshake; computes LoongArch MUL.W / MULH.W / MULH.WU over WORD/STEP cycles and
//  holds the result with out_valid until MEM takes it. Pipeline flush aborts it.
// PARAMETERS
//  WORD  32  operand width in bits
//  STEP   2  multiplier bits retired per cycle; must divide WORD (legal 1,2,4)
// PORTS
//  clk        in   1     rising-edge clock
//  rst        in   1     asynchronous reset, active-low
//  flush      in   1     abort current op, return to IDLE
//  in_valid   in   1     EX presents a multiply op
//  in_ready   out  1     unit can accept an op (state==IDLE)
//  mul_op     in   2     00 MUL.W low, 01 MULH.W signed high, 10 MULH.WU unsigned high, 11 = 00
//  src_a      in   WORD  multiplicand (rj)
//  src_b      in   WORD  multiplier (rk)
//  out_valid  out  1     mul_res valid (state==DONE)
//  out_ready  in   1     MEM consumes result
//  mul_res    out  WORD  selected 32-bit product half
//  busy       out  1     state!=IDLE (stall hint for hazard unit)
// BEHAVIOUR
//  - Reset (rst==0, async): state=IDLE, out_valid=0, busy=0, mul_res=0, acc/cnt=0.
//  - FSM IDLE->BUSY->DONE->IDLE. in_ready=1 only in IDLE; out_valid=1 only in DONE.
//  - Accept: edge where in_valid&in_ready&!flush. Latch op, cnt=0, acc(2*WORD)=0.
//    op 01: mcand=|src_a|, mplier=|src_b| (unsigned WORD-bit abs; 0x80000000 stays
//    0x80000000 = 2^31), neg=sign(a)^sign(b). ops 00/10/11: raw operands, neg=0.
//  - BUSY, each cycle: acc += (mcand * mplier[STEP-1:0]) << (cnt*STEP);
//    mplier >>= STEP; cnt++. After exactly WORD/STEP BUSY cycles go to DONE.
//  - BUSY->DONE edge: p = neg ? -acc : acc (2*WORD two's complement);
//    mul_res <= (op==01|op==10) ? p[2*WORD-1:WORD] : p[WORD-1:0].
//  - Latency: out_valid rises WORD/STEP+1 edges after the accept edge (17 @ defaults).
//  - DONE: mul_res stable, out_valid held until out_ready=1; that edge -> IDLE.
//    No accept in the same edge as completion (in_ready=0 in DONE); next accept
//    earliest one cycle later. mul_res keeps its last value after handshake.
//  - flush=1: any state -> IDLE next edge, out_valid=0, partial/held result
//    discarded, mul_res unchanged. flush beats in_valid and out_ready same cycle.
//  - Inputs ignored outside accept edge; src changes during BUSY have no effect.
//  - rst asserted mid-op: immediate abort to reset values; no output produced.
// TESTING
//  1 MUL.W a=0xFFFFFFFF b=2 -> out_valid 17 cycles after accept, mul_res=0xFFFFFFFE.
//  2 MULH.WU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULH.W a=b=0xFFFFFFFF -> 0x00000000;
//    MULH.W a=0xFFFFFFFF b=1 -> 0xFFFFFFFF.
//  3 MULH.W a=b=0x80000000 -> 0x40000000; MUL.W same -> 0x00000000.
//  4 Backpressure: out_ready=0 for 5 cycles after out_valid -> mul_res/out_valid
//    stable, in_ready=0; out_ready=1 -> IDLE next edge, in_ready=1.
//  5 flush at BUSY cycle 8 with in_valid=1 -> IDLE, no out_valid, no accept that
//    edge; new op next cycle completes correctly.
//  6 rst low mid-BUSY, then release -> all outputs reset, in_ready=1; random
//    1000-op compare vs 64-bit reference model for all mul_op, STEP=1,2,4.

Source files
------------

// File: rtl/mul_if.sv
// Handshake bundle between the EX-side issuer, the iterative multiplier and the
// MEM-side consumer.
//   flush      : abort the operation in flight
//   in_valid   : issuer presents an op      in_ready  : unit is idle and can accept
//   mul_op     : 00 MUL.W, 01 MULH.W, 10 MULH.WU, 11 same as 00
//   src_a/b    : multiplicand / multiplier
//   out_valid  : mul_res is valid           out_ready : consumer takes the result
//   mul_res    : selected product half      busy      : unit not idle (stall hint)
// master = issuer/consumer side, slave = multiplier.
interface mul_if #(
  parameter int WORD = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      mul_op;
  logic [WORD-1:0] src_a;
  logic [WORD-1:0] src_b;
  logic            out_valid;
  logic            out_ready;
  logic [WORD-1:0] mul_res;
  logic            busy;

  modport master (
    output flush, in_valid, mul_op, src_a, src_b, out_ready,
    input  in_ready, out_valid, mul_res, busy
  );

  modport slave (
    input  flush, in_valid, mul_op, src_a, src_b, out_ready,
    output in_ready, out_valid, mul_res, busy
  );
endinterface

// File: rtl/mul_unit.sv
// Iterative WORDxWORD integer multiplier producing the MUL result for the MEM
// stage. Accepts one op in IDLE, retires STEP multiplier bits per cycle over
// WORD/STEP cycles plus one finalisation cycle, then holds the selected product
// half in DONE until the consumer takes it. flush returns to IDLE from any state.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active-low
//   bus  : mul_if slave modport (handshake, operands, op select, result, busy)
module mul_unit #(
  parameter int WORD = 32,
  parameter int STEP = 2
) (
  input logic  clk,
  input logic  rst,
  mul_if.slave bus
);

  localparam int N     = WORD / STEP;
  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [2*WORD-1:0]   acc_q, acc_d;
  logic [2*WORD-1:0]   mcand_q, mcand_d;
  logic [WORD-1:0]     mplier_q, mplier_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                neg_q, neg_d;
  logic [1:0]          op_q, op_d;
  logic [WORD-1:0]     res_q, res_d;

  logic [2*WORD-1:0]   digit_ext;
  logic [2*WORD-1:0]   partial;
  logic [2*WORD-1:0]   prod;
  logic                hi_sel;

  // Unsigned WORD-bit magnitude; the most negative value maps onto itself,
  // which read as unsigned is exactly 2^(WORD-1).
  function automatic logic [WORD-1:0] abs_w(input logic [WORD-1:0] v);
    return v[WORD-1] ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WORD-1:0] neg_2w(input logic [2*WORD-1:0] v);
    return ~v + 1'b1;
  endfunction

  // mcand_q is pre-shifted left by STEP every cycle, so the partial product
  // already sits at the weight of the multiplier digit being retired.
  assign digit_ext = {{(2*WORD-STEP){1'b0}}, mplier_q[STEP-1:0]};
  assign partial   = mcand_q * digit_ext;
  assign prod      = neg_q ? neg_2w(acc_q) : acc_q;
  assign hi_sel    = (op_q == 2'b01) || (op_q == 2'b10);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    op_d     = op_q;
    res_d    = res_q;

    if (bus.flush) begin
      // Flush wins over accept and completion; the held result stays put.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            state_d = S_BUSY;
            op_d    = bus.mul_op;
            cnt_d   = '0;
            acc_d   = '0;
            if (bus.mul_op == 2'b01) begin
              mcand_d  = {{WORD{1'b0}}, abs_w(bus.src_a)};
              mplier_d = abs_w(bus.src_b);
              neg_d    = bus.src_a[WORD-1] ^ bus.src_b[WORD-1];
            end else begin
              mcand_d  = {{WORD{1'b0}}, bus.src_a};
              mplier_d = bus.src_b;
              neg_d    = 1'b0;
            end
          end
        end
        S_BUSY: begin
          if (cnt_q == CNT_W'(N)) begin
            // All digits retired: apply sign and select the product half.
            state_d = S_DONE;
            res_d   = hi_sel ? prod[2*WORD-1:WORD] : prod[WORD-1:0];
          end else begin
            acc_d    = acc_q + partial;
            mcand_d  = mcand_q << STEP;
            mplier_d = mplier_q >> STEP;
            cnt_d    = cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      op_q     <= 2'b00;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      op_q     <= op_d;
      res_q    <= res_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.mul_res   = res_q;

endmodule

// File: tb/tb_mul_unit.sv
module tb_mul_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mul_if #(.WORD(32)) m  ();
  mul_if #(.WORD(32)) m1 ();
  mul_if #(.WORD(32)) m4 ();

  // The STEP=1 and STEP=4 units see the same stimulus as the main STEP=2 unit.
  assign m1.flush     = m.flush;
  assign m1.in_valid  = m.in_valid;
  assign m1.mul_op    = m.mul_op;
  assign m1.src_a     = m.src_a;
  assign m1.src_b     = m.src_b;
  assign m1.out_ready = m.out_ready;
  assign m4.flush     = m.flush;
  assign m4.in_valid  = m.in_valid;
  assign m4.mul_op    = m.mul_op;
  assign m4.src_a     = m.src_a;
  assign m4.src_b     = m.src_b;
  assign m4.out_ready = m.out_ready;

  mul_unit #(.WORD(32), .STEP(2)) dut  (.clk(clk), .rst(rst), .bus(m.slave));
  mul_unit #(.WORD(32), .STEP(1)) dut1 (.clk(clk), .rst(rst), .bus(m1.slave));
  mul_unit #(.WORD(32), .STEP(4)) dut4 (.clk(clk), .rst(rst), .bus(m4.slave));

  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sp;
    logic [63:0]        up;
    sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    up = {32'b0, a} * {32'b0, b};
    case (op)
      2'b01:   return sp[63:32];
      2'b10:   return up[63:32];
      default: return up[31:0];
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one op for a single edge, then scrambles the operands.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    m.mul_op   = op;
    m.src_a    = a;
    m.src_b    = b;
    m.in_valid = 1'b1;
    tick();
    m.in_valid = 1'b0;
    m.src_a    = 32'hDEADBEEF;
    m.src_b    = 32'hCAFEF00D;
  endtask

  // Edges counted from the accept edge until out_valid; -1 on timeout.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!m.out_valid && lat < 100) begin
      tick();
      lat++;
    end
    if (!m.out_valid) lat = -1;
  endtask

  task automatic release_result();
    m.out_ready = 1'b1;
    tick();
    m.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    checks++;
    if ({m.in_ready, m.out_valid, m.busy} !== 3'b100) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 100", {m.in_ready, m.out_valid, m.busy});
    end
    checks++;
    if (m.mul_res !== 32'h0) begin
      errors++;
      $display("FAIL reset_res: got %h expected 00000000", m.mul_res);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_mul_w_latency();
    int lat;
    issue(2'b00, 32'hFFFFFFFF, 32'h2);
    wait_done(lat);
    checks++;
    if (lat !== 17) begin
      errors++;
      $display("FAIL mulw_latency: got %0d expected 17", lat);
    end
    checks++;
    if (m.mul_res !== 32'hFFFFFFFE) begin
      errors++;
      $display("FAIL mulw_res: got %h expected fffffffe", m.mul_res);
    end
    checks++;
    if ({m.in_ready, m.busy} !== 2'b01) begin
      errors++;
      $display("FAIL mulw_done_flags: got %b expected 01", {m.in_ready, m.busy});
    end
    release_result();
    checks++;
    if ({m.in_ready, m.out_valid, m.busy} !== 3'b100) begin
      errors++;
      $display("FAIL mulw_after_take: got %b expected 100", {m.in_ready, m.out_valid, m.busy});
    end
  endtask

  task automatic test_high_half();
    logic [1:0]  ops [5] = '{2'b10, 2'b01, 2'b01, 2'b01, 2'b00};
    logic [31:0] as  [5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000};
    logic [31:0] bs  [5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h80000000, 32'h80000000};
    logic [31:0] exp [5] = '{32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF, 32'h40000000, 32'h00000000};
    int lat;
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_done(lat);
      checks++;
      if (lat !== 17 || m.mul_res !== exp[i]) begin
        errors++;
        $display("FAIL high_half_%0d: got res %h lat %0d expected res %h lat 17",
                 i, m.mul_res, lat, exp[i]);
      end
      release_result();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    issue(2'b10, 32'h00010000, 32'h00030000);
    wait_done(lat);
    checks++;
    if (lat !== 17) begin
      errors++;
      $display("FAIL bp_latency: got %0d expected 17", lat);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({m.out_valid, m.in_ready} !== 2'b10 || m.mul_res !== 32'h3) begin
        errors++;
        $display("FAIL bp_hold_%0d: got valid/ready %b res %h expected 10 res 00000003",
                 i, {m.out_valid, m.in_ready}, m.mul_res);
      end
    end
    release_result();
    checks++;
    if ({m.in_ready, m.out_valid} !== 2'b10 || m.mul_res !== 32'h3) begin
      errors++;
      $display("FAIL bp_release: got ready/valid %b res %h expected 10 res 00000003",
               {m.in_ready, m.out_valid}, m.mul_res);
    end
  endtask

  task automatic test_flush();
    int lat;
    issue(2'b00, 32'd3, 32'd5);
    repeat (7) tick();
    m.flush    = 1'b1;
    m.in_valid = 1'b1;
    m.mul_op   = 2'b00;
    m.src_a    = 32'd7;
    m.src_b    = 32'd6;
    tick();
    m.flush = 1'b0;
    checks++;
    if ({m.in_ready, m.out_valid, m.busy} !== 3'b100) begin
      errors++;
      $display("FAIL flush_idle: got %b expected 100", {m.in_ready, m.out_valid, m.busy});
    end
    checks++;
    if (m.mul_res !== 32'h3) begin
      errors++;
      $display("FAIL flush_res_kept: got %h expected 00000003", m.mul_res);
    end
    tick();
    m.in_valid = 1'b0;
    checks++;
    if (m.busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_reaccept: got busy %b expected 1", m.busy);
    end
    wait_done(lat);
    checks++;
    if (lat !== 17 || m.mul_res !== 32'd42) begin
      errors++;
      $display("FAIL flush_next_op: got res %h lat %0d expected res 0000002a lat 17",
               m.mul_res, lat);
    end
    release_result();
  endtask

  task automatic test_rst_mid();
    int lat;
    bit seen_valid = 1'b0;
    issue(2'b01, 32'd5, 32'd7);
    repeat (5) tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({m.in_ready, m.out_valid, m.busy} !== 3'b100 || m.mul_res !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid: got flags %b res %h expected 100 res 00000000",
               {m.in_ready, m.out_valid, m.busy}, m.mul_res);
    end
    tick();
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (m.out_valid || m1.out_valid || m4.out_valid) seen_valid = 1'b1;
    end
    checks++;
    if (seen_valid !== 1'b0 || m.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_no_output: got out_valid seen %b in_ready %b expected 0 1",
               seen_valid, m.in_ready);
    end
    issue(2'b01, 32'hFFFFFFFE, 32'd3);
    wait_done(lat);
    checks++;
    if (lat !== 17 || m.mul_res !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL rst_next_op: got res %h lat %0d expected res ffffffff lat 17",
               m.mul_res, lat);
    end
    release_result();
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b, exp;
    int          n;
    // Resynchronise the three units, whose latencies differ.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    for (int k = 0; k < 1000; k++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: a = 32'h80000000;
        1: b = 32'hFFFFFFFF;
        2: a = 32'h0;
        default: ;
      endcase
      exp = ref_mul(op, a, b);
      issue(op, a, b);
      n = 0;
      while (!(m.out_valid && m1.out_valid && m4.out_valid) && n < 60) begin
        tick();
        n++;
      end
      checks++;
      if (!(m.out_valid && m1.out_valid && m4.out_valid)) begin
        errors++;
        $display("FAIL rand_timeout_%0d: got valid %b expected 111",
                 k, {m1.out_valid, m.out_valid, m4.out_valid});
      end
      checks++;
      if (m1.mul_res !== exp) begin
        errors++;
        $display("FAIL rand_step1_%0d: op %b a %h b %h got %h expected %h", k, op, a, b, m1.mul_res, exp);
      end
      checks++;
      if (m.mul_res !== exp) begin
        errors++;
        $display("FAIL rand_step2_%0d: op %b a %h b %h got %h expected %h", k, op, a, b, m.mul_res, exp);
      end
      checks++;
      if (m4.mul_res !== exp) begin
        errors++;
        $display("FAIL rand_step4_%0d: op %b a %h b %h got %h expected %h", k, op, a, b, m4.mul_res, exp);
      end
      release_result();
    end
  endtask

  initial begin
    m.flush     = 1'b0;
    m.in_valid  = 1'b0;
    m.mul_op    = 2'b00;
    m.src_a     = 32'h0;
    m.src_b     = 32'h0;
    m.out_ready = 1'b0;
    tick();
    test_reset();
    test_mul_w_latency();
    test_high_half();
    test_backpressure();
    test_flush();
    test_rst_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
